// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: multi-cycle LEGv8 control FSM with a unified memory port.
// Optional memory-ack watchdog enabled by defining LEGV8_MC_TIMEOUT_EN.
module legv8_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_src_sel,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        reg_write,
    output logic        halt,
    output logic [31:0] instr_retired
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_ADDR   = 4'd3;
    localparam logic [3:0] S_MEM_RD = 4'd4;
    localparam logic [3:0] S_MEM_WR = 4'd5;
    localparam logic [3:0] S_WB_ALU = 4'd6;
    localparam logic [3:0] S_WB_MEM = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    localparam logic [2:0] C_R   = 3'd0;
    localparam logic [2:0] C_LD  = 3'd1;
    localparam logic [2:0] C_ST  = 3'd2;
    localparam logic [2:0] C_CBZ = 3'd3;
    localparam logic [2:0] C_B   = 3'd4;
    localparam logic [2:0] C_BL  = 3'd5;
    localparam logic [2:0] C_BR  = 3'd6;
    localparam logic [2:0] C_BAD = 3'd7;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;

    logic [3:0]  state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic [2:0]  cls;
    logic [1:0]  r_op;
    logic        timeout;
    logic        retire;

    // Instruction class and R-type ALU function from the IR opcode field
    always_comb begin
        cls = (opcode == OP_ADD || opcode == OP_SUB ||
               opcode == OP_AND || opcode == OP_ORR) ? C_R   :
              (opcode == OP_LDUR)                    ? C_LD  :
              (opcode == OP_STUR)                    ? C_ST  :
              (opcode[10:3] == 8'b10110100)          ? C_CBZ :
              (opcode[10:5] == 6'b000101)            ? C_B   :
              (opcode[10:5] == 6'b100101)            ? C_BL  :
              (opcode == OP_BR)                      ? C_BR  : C_BAD;
        r_op = (opcode == OP_SUB) ? 2'b01 :
               (opcode == OP_AND) ? 2'b10 :
               (opcode == OP_ORR) ? 2'b11 : 2'b00;
    end

`ifdef LEGV8_MC_TIMEOUT_EN
    logic [31:0] wait_q;
    logic        wait_st;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // An ack arriving in the limit cycle still completes the access
    assign timeout = wait_st && !mem_ack && (wait_q == 32'(TIMEOUT_CYCLES - 1));

    // Count unacknowledged cycles; any state change restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_q <= '0;
        else
            wait_q <= (wait_st && !mem_ack && state_d == state_q) ? wait_q + 32'd1 : '0;
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
`endif

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = timeout ? S_HALT : mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (cls == C_R)                   ? S_EXEC_R :
                                (cls == C_LD || cls == C_ST)   ? S_ADDR   :
                                (cls == C_BAD)                 ? S_HALT   : S_BRANCH;
            S_EXEC_R: state_d = S_WB_ALU;
            S_ADDR:   state_d = (cls == C_ST) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_d = timeout ? S_HALT : mem_ack ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: state_d = timeout ? S_HALT : mem_ack ? S_FETCH : S_MEM_WR;
            S_WB_ALU: state_d = S_FETCH;
            S_WB_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // An instruction retires on its final transition back to FETCH
    always_comb begin
        retire = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) || (state_q == S_BRANCH) ||
                 (state_q == S_MEM_WR && mem_ack);
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    // State and retirement counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign instr_retired = retired_q;

    // Datapath controls decoded from state; held low while reset is asserted
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src_sel = 2'b00;
        alu_b_sel  = 2'b00;
        alu_op     = 2'b00;
        wb_sel     = 2'b00;
        reg_write  = 1'b0;
        halt       = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_load  = mem_ack;
                    pc_write = mem_ack;
                end
                S_EXEC_R: alu_op = r_op;
                S_ADDR:   alu_b_sel = 2'b01;
                S_MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = 1'b1;
                end
                S_WB_ALU: reg_write = 1'b1;
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'b01;
                end
                S_BRANCH: begin
                    pc_write   = (cls == C_CBZ) ? zero : 1'b1;
                    pc_src_sel = (cls == C_BR) ? 2'b10 : 2'b01;
                    alu_b_sel  = (cls == C_CBZ) ? 2'b10 : 2'b00;
                    reg_write  = (cls == C_BL);
                    wb_sel     = (cls == C_BL) ? 2'b10 : 2'b00;
                end
                S_HALT:   halt = 1'b1;
                default:  halt = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb_legv8_multicycle_ctrl: directed per-cycle vector bench for legv8_multicycle_ctrl.
module tb_legv8_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_write, reg_write, halt;
    logic [1:0]  pc_src_sel, alu_b_sel, alu_op, wb_sel;
    logic [31:0] instr_retired;
    logic [14:0] obs;

    int pass_n = 0;
    int total_n = 0;

    legv8_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
        .pc_write(pc_write), .pc_src_sel(pc_src_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .wb_sel(wb_sel), .reg_write(reg_write), .halt(halt),
        .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    // {req, we, addr, ir_load, pc_write, pc_src[2], alu_b[2], alu_op[2], wb[2], reg_write, halt}
    assign obs = {mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src_sel,
                  alu_b_sel, alu_op, wb_sel, reg_write, halt};

    localparam logic [14:0] F_A  = 15'b1_0_0_1_1_00_00_00_00_0_0;
    localparam logic [14:0] F_N  = 15'b1_0_0_0_0_00_00_00_00_0_0;
    localparam logic [14:0] IDLE = 15'b0_0_0_0_0_00_00_00_00_0_0;
    localparam logic [14:0] EXS  = 15'b0_0_0_0_0_00_00_01_00_0_0;
    localparam logic [14:0] EXA  = 15'b0_0_0_0_0_00_00_10_00_0_0;
    localparam logic [14:0] EXO  = 15'b0_0_0_0_0_00_00_11_00_0_0;
    localparam logic [14:0] WBA  = 15'b0_0_0_0_0_00_00_00_00_1_0;
    localparam logic [14:0] ADR  = 15'b0_0_0_0_0_00_01_00_00_0_0;
    localparam logic [14:0] MRD  = 15'b1_0_1_0_0_00_00_00_00_0_0;
    localparam logic [14:0] WBM  = 15'b0_0_0_0_0_00_00_00_01_1_0;
    localparam logic [14:0] MWR  = 15'b1_1_1_0_0_00_00_00_00_0_0;
    localparam logic [14:0] BB   = 15'b0_0_0_0_1_01_00_00_00_0_0;
    localparam logic [14:0] BLK  = 15'b0_0_0_0_1_01_00_00_10_1_0;
    localparam logic [14:0] BRR  = 15'b0_0_0_0_1_10_00_00_00_0_0;
    localparam logic [14:0] CZ1  = 15'b0_0_0_0_1_01_10_00_00_0_0;
    localparam logic [14:0] CZ0  = 15'b0_0_0_0_0_01_10_00_00_0_0;
    localparam logic [14:0] HLT  = 15'b0_0_0_0_0_00_00_00_00_0_1;

    typedef struct {
        logic [10:0] op;
        logic        z;
        logic        ack;
        logic [14:0] exp;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic v(input logic [10:0] op, input logic z, input logic ack,
                     input logic [14:0] exp, input logic [31:0] ret);
        vec_t r;
        r.op = op; r.z = z; r.ack = ack; r.exp = exp; r.ret = ret;
        tbl.push_back(r);
    endtask

    initial begin
        // ADD, zero-wait
        v(11'b10001011000, 0, 1, F_A, 0);  v(11'b10001011000, 0, 0, IDLE, 0);
        v(11'b10001011000, 0, 0, IDLE, 0); v(11'b10001011000, 0, 0, WBA, 0);
        // SUB, stray acks outside memory states must be ignored
        v(11'b11001011000, 0, 1, F_A, 1);  v(11'b11001011000, 0, 1, IDLE, 1);
        v(11'b11001011000, 0, 1, EXS, 1);  v(11'b11001011000, 0, 0, WBA, 1);
        // AND, ORR
        v(11'b10001010000, 0, 1, F_A, 2);  v(11'b10001010000, 0, 0, IDLE, 2);
        v(11'b10001010000, 0, 0, EXA, 2);  v(11'b10001010000, 0, 0, WBA, 2);
        v(11'b10101010000, 0, 1, F_A, 3);  v(11'b10101010000, 0, 0, IDLE, 3);
        v(11'b10101010000, 0, 0, EXO, 3);  v(11'b10101010000, 0, 0, WBA, 3);
        // LDUR, ack delayed 3 cycles in FETCH and MEM_RD; WB_MEM at cycle 11
        for (int i = 0; i < 3; i++) v(11'b11111000010, 0, 0, F_N, 4);
        v(11'b11111000010, 0, 1, F_A, 4);  v(11'b11111000010, 0, 0, IDLE, 4);
        v(11'b11111000010, 0, 0, ADR, 4);
        for (int i = 0; i < 3; i++) v(11'b11111000010, 0, 0, MRD, 4);
        v(11'b11111000010, 0, 1, MRD, 4);  v(11'b11111000010, 0, 0, WBM, 4);
        // STUR, one wait in FETCH and one in MEM_WR
        v(11'b11111000000, 0, 0, F_N, 5);  v(11'b11111000000, 0, 1, F_A, 5);
        v(11'b11111000000, 0, 0, IDLE, 5); v(11'b11111000000, 0, 0, ADR, 5);
        v(11'b11111000000, 0, 0, MWR, 5);  v(11'b11111000000, 0, 1, MWR, 5);
        // CBZ taken, then not taken
        v(11'b10110100101, 1, 1, F_A, 6);  v(11'b10110100101, 1, 0, IDLE, 6);
        v(11'b10110100101, 1, 0, CZ1, 6);
        v(11'b10110100000, 0, 1, F_A, 7);  v(11'b10110100000, 0, 0, IDLE, 7);
        v(11'b10110100000, 0, 0, CZ0, 7);
        // B, BL, BR
        v(11'b00010111111, 0, 1, F_A, 8);  v(11'b00010111111, 0, 0, IDLE, 8);
        v(11'b00010111111, 0, 1, BB, 8);
        v(11'b10010100001, 0, 1, F_A, 9);  v(11'b10010100001, 0, 0, IDLE, 9);
        v(11'b10010100001, 1, 1, BLK, 9);
        v(11'b11010110000, 0, 1, F_A, 10); v(11'b11010110000, 0, 0, IDLE, 10);
        v(11'b11010110000, 0, 1, BRR, 10);

        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(obs), 32'(IDLE));
        chk("reset_retired", instr_retired, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            opcode = tbl[i].op; zero = tbl[i].z; mem_ack = tbl[i].ack;
            #1;
            chk($sformatf("vec%0d_outputs", i), 32'(obs), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_retired", i), instr_retired, tbl[i].ret);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        #1 chk("retired_after_table", instr_retired, 32'd11);

        // Unknown opcode: HALT after DECODE, sticky, acks ignored
        opcode = 11'b00000000000; mem_ack = 1'b1;
        #1 chk("bad_fetch", 32'(obs), 32'(F_A));
        @(negedge clk); mem_ack = 1'b0;
        #1 chk("bad_decode", 32'(obs), 32'(IDLE));
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            mem_ack = 1'($urandom); zero = 1'($urandom);
            #1;
            chk($sformatf("halt_hold%0d", c), 32'(obs), 32'(HLT));
            chk($sformatf("halt_retired%0d", c), instr_retired, 32'd11);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle clears halt and the counter at once
        mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(obs), 32'(IDLE));
        chk("async_reset_retired", instr_retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef LEGV8_MC_TIMEOUT_EN
        for (int c = 1; c <= 17; c++) begin
            #1;
            if (c == 16) chk("timeout_last_wait", 32'(obs), 32'(F_N));
            if (c == 17) chk("timeout_halt", 32'(obs), 32'(HLT));
            if (c < 17) @(negedge clk);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            #1;
            if (c == 1) chk("no_ack_first_req", 32'(obs), 32'(F_N));
            if (c == 100) chk("no_ack_still_fetch", 32'(obs), 32'(F_N));
            if (c < 100) @(negedge clk);
        end
`endif
        // Reset during an outstanding request drops it immediately
        #2 rst_n = 1'b0;
        #1 chk("abandon_req", 32'(mem_req), 32'd0);
        chk("abandon_halt", 32'(halt), 32'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
